// File: rtl/mux_arb_rr.sv
// N:1 registered valid/ready multiplexer with fixed-select or round-robin channel choice.
// Optional accepted-transfer counter on grant_cnt, built when MUX_ARB_GRANT_CNT_EN is defined.
module mux_arb_rr #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready,
    output logic [15:0]             grant_cnt
);

    localparam int unsigned CNT_W = 16;

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic [SEL_W-1:0]  ptr;
    logic              load_en;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;
    int unsigned       scan_pos;
    logic [SEL_W-1:0]  scan_idx;

    // One-hot grant: direct select in mode 0, first valid at or after ptr (wrapping) in mode 1
    always_comb begin : grant_logic
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_pos  = 0;
        scan_idx  = '0;
        if (!mode) begin
            if ((32'(select) < NUM_CH) && in_valid[select]) begin
                grant[select] = 1'b1;
                grant_idx     = select;
                grant_any     = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                scan_pos = 32'(ptr) + k;
                if (scan_pos >= NUM_CH) begin
                    scan_pos = scan_pos - NUM_CH;
                end
                scan_idx = SEL_W'(scan_pos);
                if (!grant_any && in_valid[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                    grant_any       = 1'b1;
                end
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign xfer     = grant_any && load_en && rst_n;
    assign sel_data = in_data[32'(grant_idx)*WIDTH +: WIDTH];

    // Single-entry output stage; a load in the same cycle as a drain keeps out_valid high
    always_ff @(posedge clk) begin : out_stage
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
            if (mode) begin
                ptr <= (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of accepted input transfers
    always_ff @(posedge clk) begin : grant_counter
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mux_arb_rr.sv
// Self-checking bench for mux_arb_rr (WIDTH=32, NUM_CH=8): reference model plus scoreboard queue
// of accepted words, with directed checks for the key scenarios.
module tb_mux_arb_rr;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] ch;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_ready;
    logic [15:0]             grant_cnt;

    int checks = 0;
    int errors = 0;

    exp_t              sb_q[$];
    logic              m_valid;
    logic [SEL_W-1:0]  m_ptr;
    logic [15:0]       m_cnt;
    logic [NUM_CH-1:0] m_xfer;

    logic [SEL_W-1:0] rr_seq [5] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};

    mux_arb_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .select    (select),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int ch, input logic [WIDTH-1:0] w);
        in_data[ch*WIDTH +: WIDTH] = w;
    endtask

    // One clock: check DUT against model at negedge, advance model, return at posedge+1
    task automatic cyc();
        logic             g_any;
        logic [SEL_W-1:0] g_idx;
        logic             le;
        logic [NUM_CH-1:0] exp_rdy;
        int               idx;
        exp_t             e;
        @(negedge clk);
        g_any = 1'b0;
        g_idx = '0;
        if (!mode) begin
            if (int'(select) < NUM_CH && in_valid[select]) begin
                g_any = 1'b1;
                g_idx = select;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (int'(m_ptr) + k) % NUM_CH;
                if (!g_any && in_valid[idx]) begin
                    g_any = 1'b1;
                    g_idx = SEL_W'(idx);
                end
            end
        end
        le      = !m_valid || out_ready;
        exp_rdy = (rst_n && g_any && le) ? (NUM_CH'(1) << g_idx) : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid && sb_q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(sb_q[0].d));
            chk("out_ch", 64'(out_ch), 64'(sb_q[0].ch));
        end
        chk("grant_cnt", 64'(grant_cnt), 64'(m_cnt));
        m_xfer = exp_rdy & in_valid;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ptr   = '0;
            m_cnt   = '0;
            sb_q.delete();
        end else begin
            if (m_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (exp_rdy != '0) begin
                e.d  = in_data[int'(g_idx)*WIDTH +: WIDTH];
                e.ch = g_idx;
                sb_q.push_back(e);
                m_valid = 1'b1;
                if (mode) m_ptr = (g_idx == SEL_W'(NUM_CH - 1)) ? '0 : g_idx + 3'd1;
`ifdef MUX_ARB_GRANT_CNT_EN
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_valid   = 1'b0;
        m_ptr     = '0;
        m_cnt     = '0;
        m_xfer    = '0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        select    = '0;
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int i = 0; i < NUM_CH; i++) set_word(i, 32'h1000_0000 + 32'(i));

        // 1. reset held for two clocks with every channel valid
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'h00);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        rst_n = 1'b1;

        // 2. fixed select of channel 4
        mode      = 1'b0;
        select    = 3'd4;
        out_ready = 1'b1;
        set_word(4, 32'h6546_5666);
        #1;
        chk("fix_in_ready", 64'(in_ready), 64'h10);
        cyc();
        chk("fix_out_valid", 64'(out_valid), 64'd1);
        chk("fix_out_data", 64'(out_data), 64'h6546_5666);
        chk("fix_out_ch", 64'(out_ch), 64'd4);

        // 3. round-robin over channels 0, 2, 7
        mode     = 1'b1;
        in_valid = 8'b1000_0101;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("rr_out_ch", 64'(out_ch), 64'(rr_seq[j]));
            chk("rr_no_bubble", 64'(out_valid), 64'd1);
        end

        // 4. backpressure on a held word, then drain and load in one cycle
        mode     = 1'b0;
        select   = 3'd1;
        in_valid = 8'h02;
        set_word(1, 32'hFFFF_FFFA);
        cyc();
        chk("bp_loaded", 64'(out_data), 64'hFFFF_FFFA);
        out_ready = 1'b0;
        set_word(1, 32'h0BAD_F00D);
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'h00);
            cyc();
            chk("bp_out_data", 64'(out_data), 64'hFFFF_FFFA);
            chk("bp_out_ch", 64'(out_ch), 64'd1);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h02);
        cyc();
        chk("bp_next_data", 64'(out_data), 64'h0BAD_F00D);
        chk("bp_next_valid", 64'(out_valid), 64'd1);

        // 5a. selected channel not valid
        select   = 3'd3;
        in_valid = 8'hF7;
        #1;
        chk("nogrant_ready", 64'(in_ready), 64'h00);
        cyc();
        chk("nogrant_out_valid", 64'(out_valid), 64'd0);

        // 5b. reset pulse while stalled clears output and pointer
        mode     = 1'b1;
        in_valid = 8'h30;
        cyc();
        chk("stall_pre_ch", 64'(out_ch), 64'd4);
        out_ready = 1'b0;
        cyc();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rstpulse_in_ready", 64'(in_ready), 64'h00);
        cyc();
        rst_n = 1'b1;
        chk("rstpulse_out_valid", 64'(out_valid), 64'd0);
        in_valid = 8'h81;
        #1;
        chk("rstpulse_ptr0", 64'(in_ready), 64'h01);

        // 6. transfer counter
        for (int j = 0; j < 5; j++) cyc();
`ifdef MUX_ARB_GRANT_CNT_EN
        chk("cnt_five", 64'(grant_cnt), 64'd5);
        for (int j = 0; j < 65535; j++) cyc();
        chk("cnt_saturated", 64'(grant_cnt), 64'hFFFF);
`else
        chk("cnt_disabled", 64'(grant_cnt), 64'd0);
`endif

        // random traffic with protocol-compliant producers
        for (int j = 0; j < 200; j++) begin
            mode      = 1'($urandom_range(0, 1));
            select    = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_xfer[i]) in_valid[i] = 1'b0;
                if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
                    in_valid[i] = 1'b1;
                    set_word(i, $urandom);
                end
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
